uart_rx_bytes: RTL
==================

# uart_rx_bytes

- Serial receive front end for the accelerator; it sits directly upstream of the byte-assembly stage that packs bytes into 64-bit matrix operands.
- Receives 8N1 UART frames (optionally 8E1) on a single line, oversampled by the system clock.
- Validates start, stop and (optionally) parity bits.
- Queues good bytes in a small first-word-fall-through FIFO and presents them with a valid/ready handshake; one accepted transfer is one byte write into the assembler.

## Interface
- CLKS_PER_BIT, default 16: system clock cycles per bit period; must be ≥ 4.
- FIFO_DEPTH, default 4: receive FIFO entries; must be a power of 2, ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line, idles high.
- data_out  out  8  FIFO head byte; valid only while data_valid=1.
- data_valid  out  1  FIFO not empty.
- data_ready  in  1  consumer accepts head this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.

## Operation
- Reset values:
  - rx_serial synchronizer stages reset to 1.
  - FSM resets to IDLE; bit and cycle counters reset to 0; FIFO is empty.
  - data_out=0, data_valid=0, fifo_level=0, all error pulses 0.
- The FSM sees rx_serial only through a 2-flop synchronizer (rx_s).
- FSM states:
  - IDLE: rx_s=0 → START, cycle counter cleared.
  - START: wait (CLKS_PER_BIT-1)/2 cycles, then sample rx_s. If 0 → DATA. If 1 → IDLE (glitch rejected, nothing reported).
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After bit 7 → PARITY if compiled in, else STOP.
  - PARITY: one bit period later, sample and compare against even parity of the 8 data bits.
  - STOP: one bit period later, sample the stop bit.
    - Stop=1 and no parity error: push the byte; if the FIFO is full and not popping this cycle, drop it and pulse overrun. → IDLE.
    - Stop=1 with parity error: drop the byte, pulse parity_err. → IDLE.
    - Stop=0: drop the byte, pulse frame_err (parity_err also pulses if parity mismatched). → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. A held-low line (break) yields exactly one frame_err.
- Error outputs are pulses, not sticky; the same-cycle coincidences are listed under Timing.
- FIFO behaviour:
  - Circular buffer, FIFO_DEPTH entries; read and write pointers wrap modulo FIFO_DEPTH.
  - Pop when data_valid & data_ready; data_ready while empty is ignored.
  - Push and pop in the same cycle: both take effect and fifo_level is unchanged. This includes the full case, where no overrun is raised.
  - data_out always shows the head entry combinationally from storage.

## Timing
- Frame start to sample points: the start edge at rx_serial is recognised in IDLE 2 cycles later (synchronizer).
  - Data bit k is sampled at (CLKS_PER_BIT-1)/2 + (k+1)·CLKS_PER_BIT cycles after entering START.
  - Stop bit is sampled one further bit period after bit 7, or two with parity.
- Stop-sample cycle to output: the push registers on that edge.
  - data_valid rises and data_out shows the byte 1 cycle after the stop-sample cycle.
  - fifo_level and error pulses also update on that edge.
- Back-to-back frames: the FSM is back in IDLE half a bit period before the nominal stop-bit end, so a start bit immediately following is not missed.
- Reset asserted mid-frame or with a non-empty FIFO:
  - All state is cleared asynchronously; the partial byte and FIFO contents are discarded.
  - After release, the block waits in IDLE for a falling edge; a line already low is treated as a start.

## Configuration
- UART_RX_PARITY_EN defined: frames are 8E1; the PARITY state and parity check exist; parity_err is driven.
- UART_RX_PARITY_EN undefined: frames are 8N1; the PARITY state is absent; parity_err is constant 0; port list unchanged.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 then 0x3C back-to-back, data_ready=1 → data_out 0xA5 then 0x3C, each with a one-cycle data_valid; no error pulses.
- Pulse rx_serial low for 4 cycles → FSM returns to IDLE after START; no push; no frame_err; fifo_level stays 0.
- Send 0x55 with stop bit forced 0, then hold the line low for 40 cycles → exactly one frame_err pulse, no byte, FSM in BREAK until the line goes high; a following 0x12 is received correctly.
- data_ready=0, FIFO_DEPTH=4, send 0x01..0x05 → fifo_level reaches 4, overrun pulses once on the fifth byte. Then raise data_ready → reads 0x01,0x02,0x03,0x04 in order, data_valid falls.
- Assert rst midway through the data bits of 0xFF with 2 bytes queued → all outputs return to 0 immediately; after release, 0x81 is received as the only byte.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) → parity_err pulse, no push. Send 0x07 with parity bit 1 → 0x07 delivered.

Source files
------------

// File: rtl/uart_rx_bytes.sv
// uart_rx_bytes: UART receive front end. The line is oversampled by the system clock.
// Frames are 8N1 by default. Defining UART_RX_PARITY_EN switches to 8E1 and adds
// the parity state and parity check.
// Good bytes are queued in a first-word-fall-through FIFO. The FIFO head is
// presented on a valid/ready handshake.
module uart_rx_bytes #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_serial,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cyc_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            bit_tick;
  logic            push_req;
  logic            par_bad;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, pop, do_push;

  // Two-flop synchronizer on the asynchronous line; idles high so reset never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  assign bit_tick = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
  // A byte is offered to the FIFO on the stop-sample cycle when the frame is clean.
  assign push_req = (state == STOP) && bit_tick && rx_s && !par_bad;

`ifdef UART_RX_PARITY_EN
  // Receive FSM with the parity state. The error pulses are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          par_bad <= 1'b0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cyc_cnt == CW'(HALF)) begin
            cyc_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        DATA: begin
          if (bit_tick) begin
            cyc_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        PARITY: begin
          if (bit_tick) begin
            cyc_cnt <= '0;
            par_bad <= (rx_s != ^shift);
            state   <= STOP;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        STOP: begin
          if (bit_tick) begin
            cyc_cnt    <= '0;
            parity_err <= par_bad;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else state <= IDLE;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;

  // Receive FSM for 8N1 frames. The frame error pulse is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cyc_cnt == CW'(HALF)) begin
            cyc_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        DATA: begin
          if (bit_tick) begin
            cyc_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        STOP: begin
          if (bit_tick) begin
            cyc_cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else state <= IDLE;
          end else cyc_cnt <= cyc_cnt + CW'(1);
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  assign data_valid = (fifo_level != '0);
  assign pop        = data_valid && data_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push    = push_req && (!full || pop);
  assign data_out   = mem[rd_ptr];

  // Circular FIFO storage, pointers, occupancy and the overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push_req && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule
